shift_seq: RTL
==============

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter WIDTH, 16, data width of operand and result.
REQ-002 Parameter CNT_W, 4, width of shift-count field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  2  operation: 00 ROL, 01 SLL, 10 ROR, 11 SRA.
REQ-007 in  input  WIDTH  operand, captured on accepted start.
REQ-008 cnt  input  CNT_W  shift amount, captured on accepted start.
REQ-009 flush  input  1  pipeline flush; aborts operation in progress.
REQ-010 busy  output  1  high while an operation is in flight (SHIFT or DONE).
REQ-011 done  output  1  one-cycle pulse when out holds a new result.
REQ-012 out  output  WIDTH  result register; held between operations.

Function
REQ-013 The block SHALL sequence a 1-bit-per-cycle shifter/rotator with FSM states IDLE, SHIFT, DONE.
REQ-014 In IDLE with start=1 and flush=0, the block SHALL capture in into acc, cnt into remaining, op into op_q, and set busy next cycle.
REQ-015 On accept with cnt=0, the block SHALL go IDLE->DONE; otherwise IDLE->SHIFT.
REQ-016 In SHIFT, each cycle SHALL apply one 1-bit step of op_q to acc and decrement remaining; when remaining=1 the step SHALL be the last and the FSM SHALL go to DONE.
REQ-017 Step rules: ROL {acc[W-2:0],acc[W-1]}; SLL {acc[W-2:0],0}; ROR {acc[0],acc[W-1:1]}; SRA {acc[W-1],acc[W-1:1]}.
REQ-018 On entering DONE, out SHALL load acc; in DONE, done=1 for exactly one cycle, then FSM SHALL return to IDLE.
REQ-019 Latency from accepted start to done SHALL be cnt+1 cycles (cnt=0 -> 1, cnt=15 -> 16).
REQ-020 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; a new start SHALL be accepted the cycle after done (back-to-back spacing cnt+2).
REQ-021 start while busy=1 SHALL be ignored with no effect on acc, remaining, op_q or out.
REQ-022 flush in SHIFT or DONE SHALL force IDLE next cycle with done=0 and out unchanged; flush has priority over done generation.
REQ-023 flush and start together in IDLE SHALL not accept the start.
REQ-024 op, in, cnt SHALL be don't-care except on the accepting cycle.

Reset
REQ-025 rst=1 SHALL, at the next edge, force IDLE, busy=0, done=0, out=0, acc=0, remaining=0, op_q=00.
REQ-026 rst SHALL override start and flush and abort any operation mid-SHIFT or in DONE with no done pulse.

Structure
REQ-027 Op encodings (ROL, SLL, ROR, SRA) and FSM state encodings SHALL live in shared package shift_pkg.
REQ-028 The 1-bit step SHALL be a combinational sub-module shift1 (acc, op -> next acc); FSM, counter and registers SHALL be in shift_seq.

Verification
REQ-029 ROL in=16'h8001 cnt=1 -> done 2 cycles after start, out=16'h0003.
REQ-030 SRA in=16'h8000 cnt=15 -> done 16 cycles after start, out=16'hFFFF; SLL in=16'h00FF cnt=4 -> out=16'h0FF0.
REQ-031 ROR in=16'h0001 cnt=4 -> out=16'h1000; any op in=16'hA5A5 cnt=0 -> done 1 cycle after start, out=16'hA5A5.
REQ-032 Second start (in=16'hFFFF) asserted during SHIFT of ROL 16'h0001 cnt=3 -> ignored, out=16'h0008.
REQ-033 flush on 2nd SHIFT cycle of SLL 16'h0001 cnt=8 after prior result 16'h1234 -> no done, busy=0 next cycle, out=16'h1234.
REQ-034 rst mid-SHIFT -> next cycle busy=0, done=0, out=16'h0000; following start ROL 16'h0001 cnt=2 -> out=16'h0004.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the bit-serial shifter: operation codes and sequencer states.
package shift_pkg;

  typedef enum logic [1:0] {
    OpRol = 2'b00,
    OpSll = 2'b01,
    OpRor = 2'b10,
    OpSra = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift1.sv
// Single-step shifter/rotator: applies one 1-bit move of the selected operation.
module shift1
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc_i,
  input  shift_op_e        op_i,
  output logic [WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    unique case (op_i)
      OpRol: acc_o = {acc_i[WIDTH-2:0], acc_i[WIDTH-1]};
      OpSll: acc_o = {acc_i[WIDTH-2:0], 1'b0};
      OpRor: acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
      OpSra: acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Sequencer for a 1-bit-per-cycle shifter: captures an operand, steps it cnt times,
// then publishes the result with a one-cycle done pulse.
module shift_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] cnt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  shift_op_e        op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] step;

  shift1 #(
    .WIDTH(WIDTH)
  ) u_shift1 (
    .acc_i(acc_q),
    .op_i (op_q),
    .acc_o(step)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          acc_d = in;
          rem_d = cnt;
          op_d  = shift_op_e'(op);
          if (cnt == '0) begin
            state_d = StDone;
            out_d   = in;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step;
          rem_d = rem_q - CNT_W'(1);
          // Last step: publish the freshly shifted value as we enter DONE.
          if (rem_q == CNT_W'(1)) begin
            state_d = StDone;
            out_d   = step;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= OpRol;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q != StIdle);
  // A flush arriving in DONE suppresses the pulse.
  assign done = (state_q == StDone) && !flush;
  assign out  = out_q;

endmodule
